// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan path.
//   state_t : scan FSM states
//   SEG_OFF : all segments dark (active low)
//   SEG_LUT : hex nibble -> {g,f,e,d,c,b,a}, active low
package seg_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, SHOW = 2'd1, BLANK = 2'd2} state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Element 0 is the rightmost entry.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display bus between a value producer / display pins and seg_scan_ctrl.
//   master : drives enable, lz_blank, load_*; observes ready and display pins
//   slave  : the scan controller
interface seg_scan_ctrl_if;
  logic        enable;
  logic        lz_blank;
  logic        load_valid;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic        load_ready;
  logic [1:0]  digit_sel;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  modport master (
    output enable, lz_blank, load_valid, load_data, load_dp,
    input  load_ready, digit_sel, an_n, seg_n, dp_n
  );
  modport slave (
    input  enable, lz_blank, load_valid, load_data, load_dp,
    output load_ready, digit_sel, an_n, seg_n, dp_n
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph.
//   i_nib   : hex digit 0..F
//   o_seg_n : {g,f,e,d,c,b,a}, active low
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg_n
);
  assign o_seg_n = SEG_LUT[i_nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode scan controller with per-slot blanking guard and
// frame-aligned value updates.
//   i_clk, i_rst : clock, async active-high reset
//   bus          : enable/lz_blank, load valid/ready/data/dp, digit_sel,
//                  an_n, seg_n, dp_n (all display outputs registered)
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  seg_scan_ctrl_if.slave  bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [1:0]      r_digit, w_digit_nx;
  logic            w_wrap;

  logic [15:0]     r_active, r_shadow;
  logic [3:0]      r_act_dp, r_shd_dp;
  logic            r_shadow_full;
  logic            w_accept, w_commit;

  logic [3:0]      w_lz;
  logic [3:0]      w_nib;
  logic [6:0]      w_seg_n;
  logic            w_on;
  logic [3:0]      r_an_n;
  logic [6:0]      r_seg_n;
  logic            r_dp_n;
  logic [1:0]      r_sel;

  // Scan FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_digit <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_digit <= w_digit_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_digit_nx = r_digit;
    w_wrap     = 1'b0;
    case (r_state)
      OFF: begin
        w_cnt_nx   = '0;
        w_digit_nx = '0;
        if (bus.enable) w_state_nx = SHOW;
      end
      SHOW: begin
        w_cnt_nx = r_cnt + CW'(1);
        if (r_cnt == SHOW_LAST) w_state_nx = BLANK;
      end
      BLANK: begin
        if (r_cnt == SLOT_LAST) begin
          w_cnt_nx   = '0;
          w_digit_nx = r_digit + 2'd1;
          w_state_nx = SHOW;
          w_wrap     = (r_digit == 2'd3);
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: w_state_nx = OFF;
    endcase
    if (!bus.enable) begin
      w_state_nx = OFF;
      w_cnt_nx   = '0;
      w_digit_nx = '0;
    end
  end

  // Shadow/active value. Commit looks at the registered full flag, so a
  // value accepted on the wrap cycle itself waits for the following wrap.
  assign w_accept = bus.load_valid && !r_shadow_full;
  assign w_commit = r_shadow_full && ((r_state == OFF) || w_wrap);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow      <= '0;
      r_shd_dp      <= '0;
      r_shadow_full <= 1'b0;
      r_active      <= '0;
      r_act_dp      <= '0;
    end else begin
      if (w_accept) begin
        r_shadow      <= bus.load_data;
        r_shd_dp      <= bus.load_dp;
        r_shadow_full <= 1'b1;
      end else if (w_commit) begin
        r_shadow_full <= 1'b0;
      end
      if (w_commit) begin
        r_active <= r_shadow;
        r_act_dp <= r_shd_dp;
      end
    end
  end

  // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 always lights.
  assign w_lz[0] = 1'b0;
  for (genvar k = 1; k < 4; k++) begin : g_lz
    assign w_lz[k] = bus.lz_blank && (r_active[15:4*k] == '0);
  end

  assign w_nib = r_active[{r_digit, 2'b00} +: 4];
  assign w_on  = (r_state == SHOW) && !w_lz[r_digit];

  hex_to_seg7 u_h2s (.i_nib(w_nib), .o_seg_n(w_seg_n));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_an_n  <= 4'hF;
      r_seg_n <= SEG_OFF;
      r_dp_n  <= 1'b1;
      r_sel   <= '0;
    end else begin
      r_an_n  <= w_on ? ~(4'b0001 << r_digit) : 4'hF;
      r_seg_n <= w_on ? w_seg_n : SEG_OFF;
      r_dp_n  <= w_on ? ~r_act_dp[r_digit] : 1'b1;
      r_sel   <= r_digit;
    end
  end

  assign bus.load_ready = !r_shadow_full;
  assign bus.an_n       = r_an_n;
  assign bus.seg_n      = r_seg_n;
  assign bus.dp_n       = r_dp_n;
  assign bus.digit_sel  = r_sel;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl_if sif ();

  seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (sif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] seg,
                         input logic dpn, input logic [1:0] sel, input logic rdy);
    ck({tag, "_an"},  16'(sif.an_n),       16'(an));
    ck({tag, "_seg"}, 16'(sif.seg_n),      16'(seg));
    ck({tag, "_dp"},  16'(sif.dp_n),       16'(dpn));
    ck({tag, "_sel"}, 16'(sif.digit_sel),  16'(sel));
    ck({tag, "_rdy"}, 16'(sif.load_ready), 16'(rdy));
  endtask

  // One 8-cycle digit slot as seen on the registered outputs: 6 lit, 2 blank.
  // load_valid is dropped after the first cycle so a one-shot offer can be
  // set up just before calling.
  task automatic slot(input logic [1:0] d, input logic [3:0] an, input logic [6:0] seg,
                      input logic dpn, input logic rl, input logic re);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) sif.load_valid = 1'b0;
      if (i < 6) chk_out($sformatf("d%0d_show%0d", d, i), an, seg, dpn, d, rl);
      else       chk_out($sformatf("d%0d_blank%0d", d, i), 4'hF, 7'h7F, 1'b1, d,
                         (i == 7) ? re : rl);
    end
  endtask

  // Full frame, shadow empty. segs = {s3,s2,s1,s0}; lit = digits expected to light.
  task automatic frame(input logic [27:0] segs, input logic [3:0] dpn, input logic [3:0] lit);
    logic [3:0] an_e;
    for (int d = 0; d < 4; d++) begin
      an_e = ~(4'b0001 << d);
      if (lit[d]) slot(2'(d), an_e, segs[d*7 +: 7], dpn[d], 1'b1, 1'b1);
      else        slot(2'(d), 4'hF, 7'h7F, 1'b1, 1'b1, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    sif.enable = 1'b0; sif.lz_blank = 1'b0;
    sif.load_valid = 1'b0; sif.load_data = '0; sif.load_dp = '0;
    #2;
    chk_out("reset", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b1);

    // Load 1234 while off: accept, then commit on the next cycle.
    @(posedge clk); #1; rst = 1'b0;
    sif.load_valid = 1'b1; sif.load_data = 16'h1234; sif.load_dp = 4'h0;
    tick(); sif.load_valid = 1'b0;
    ck("off_accept_rdy", 16'(sif.load_ready), 16'd0);
    tick();
    ck("off_commit_rdy", 16'(sif.load_ready), 16'd1);

    // Scan 1234 for two frames.
    sif.enable = 1'b1;
    tick(); chk_out("en_first", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b1);
    frame({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF);
    frame({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF);

    // Offer ABCD (dp on digit 1) as digit 1 starts; old nibbles until wrap.
    slot(2'd0, 4'b1110, 7'h19, 1'b1, 1'b1, 1'b1);
    sif.load_valid = 1'b1; sif.load_data = 16'hABCD; sif.load_dp = 4'b0010;
    slot(2'd1, 4'b1101, 7'h30, 1'b1, 1'b0, 1'b0);
    slot(2'd2, 4'b1011, 7'h24, 1'b1, 1'b0, 1'b0);
    slot(2'd3, 4'b0111, 7'h79, 1'b1, 1'b0, 1'b1);
    frame({7'h08, 7'h03, 7'h46, 7'h21}, 4'b1101, 4'hF);

    // Drop enable mid-SHOW of digit 2.
    slot(2'd0, 4'b1110, 7'h21, 1'b1, 1'b1, 1'b1);
    slot(2'd1, 4'b1101, 7'h46, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out($sformatf("d2_pre_dis%0d", i), 4'b1011, 7'h03, 1'b1, 2'd2, 1'b1);
    end
    sif.enable = 1'b0;
    tick(); tick();
    chk_out("disabled", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b1);

    // Leading-zero suppression on 0005; restart at digit 0 with full slot.
    sif.lz_blank = 1'b1;
    sif.load_valid = 1'b1; sif.load_data = 16'h0005; sif.load_dp = 4'h0;
    tick(); sif.load_valid = 1'b0;
    tick();
    sif.enable = 1'b1;
    tick(); chk_out("reen_first", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b1);
    frame({7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, 4'b0001);

    // Leading-zero suppression on 0000.
    sif.enable = 1'b0;
    tick(); tick();
    sif.load_valid = 1'b1; sif.load_data = 16'h0000; sif.load_dp = 4'h0;
    tick(); sif.load_valid = 1'b0;
    tick();
    sif.enable = 1'b1;
    tick(); chk_out("zero_first", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b1);
    frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'b0001);

    // Async reset mid-BLANK with a pending 8888 in the shadow.
    sif.lz_blank = 1'b0;
    sif.load_valid = 1'b1; sif.load_data = 16'h8888; sif.load_dp = 4'hF;
    slot(2'd0, 4'b1110, 7'h40, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk_out("pre_rst", 4'b1101, 7'h40, 1'b1, 2'd1, 1'b0);
    #2; rst = 1'b1;
    #1; chk_out("async_rst", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b1);
    @(posedge clk); #1; rst = 1'b0;
    tick(); chk_out("post_rst_first", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b1);
    frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
